// File: rtl/reg_scoreboard_if.sv
// Decode, retire and status bundle between the pipeline and reg_scoreboard.
// The scalar and vector register files each have their own issue, writeback and squash fields.
interface reg_scoreboard_if;
    logic        dec_valid;
    logic        dec_s_rs1_en;
    logic        dec_s_rs2_en;
    logic [4:0]  dec_s_rs1;
    logic [4:0]  dec_s_rs2;
    logic        dec_v_rs1_en;
    logic        dec_v_rs2_en;
    logic [4:0]  dec_v_rs1;
    logic [4:0]  dec_v_rs2;
    logic        dec_s_rd_en;
    logic        dec_v_rd_en;
    logic [4:0]  dec_s_rd;
    logic [4:0]  dec_v_rd;
    logic        wb_s_en;
    logic        wb_v_en;
    logic [4:0]  wb_s_addr;
    logic [4:0]  wb_v_addr;
    logic        kill_s_en;
    logic        kill_v_en;
    logic [4:0]  kill_s_addr;
    logic [4:0]  kill_v_addr;
    logic        stall;
    logic        issue;
    logic [31:0] s_pending;
    logic [31:0] v_pending;
    logic        idle;
    logic        err_underflow;

    modport master (
        output dec_valid,
        output dec_s_rs1_en, dec_s_rs2_en, dec_s_rs1, dec_s_rs2,
        output dec_v_rs1_en, dec_v_rs2_en, dec_v_rs1, dec_v_rs2,
        output dec_s_rd_en, dec_v_rd_en, dec_s_rd, dec_v_rd,
        output wb_s_en, wb_v_en, wb_s_addr, wb_v_addr,
        output kill_s_en, kill_v_en, kill_s_addr, kill_v_addr,
        input  stall, issue, s_pending, v_pending, idle, err_underflow
    );

    modport slave (
        input  dec_valid,
        input  dec_s_rs1_en, dec_s_rs2_en, dec_s_rs1, dec_s_rs2,
        input  dec_v_rs1_en, dec_v_rs2_en, dec_v_rs1, dec_v_rs2,
        input  dec_s_rd_en, dec_v_rd_en, dec_s_rd, dec_v_rd,
        input  wb_s_en, wb_v_en, wb_s_addr, wb_v_addr,
        input  kill_s_en, kill_v_en, kill_s_addr, kill_v_addr,
        output stall, issue, s_pending, v_pending, idle, err_underflow
    );
endinterface

// File: rtl/reg_scoreboard.sv
// Scoreboard of outstanding writes to the scalar and vector register files.
// Define WB_BYPASS_EN to let a source whose last outstanding write is retiring this cycle issue.
module reg_scoreboard #(
    parameter int CNT_W      = 2,
    parameter int TOT_W      = 6,
    parameter int S_ZERO_REG = 1
) (
    input logic          clk,
    input logic          rst_n,
    reg_scoreboard_if.slave sb
);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [TOT_W:0]   TOT_MAX = {1'b0, {TOT_W{1'b1}}};

    logic [CNT_W-1:0] s_cnt [32];
    logic [CNT_W-1:0] v_cnt [32];
    logic [CNT_W-1:0] s_nxt [32];
    logic [CNT_W-1:0] v_nxt [32];
    logic [31:0]      s_uf;
    logic [31:0]      v_uf;
    logic [TOT_W-1:0] total;
    logic [TOT_W-1:0] tot_nxt;
    logic             tot_uf;
    logic             err_q;

    function automatic logic s_track(input logic [4:0] a);
        return (S_ZERO_REG == 0) || (a != 5'd0);
    endfunction

    // Returns {underflow, next count}; a negative result clamps to zero.
    function automatic logic [CNT_W:0] cnt_upd(
        input logic [CNT_W-1:0] cnt,
        input logic             inc,
        input logic [1:0]       dec
    );
        logic [CNT_W:0] sum;
        logic [CNT_W:0] diff;
        sum  = {1'b0, cnt} + (CNT_W+1)'(inc);
        diff = sum - (CNT_W+1)'(dec);
        if ((CNT_W+1)'(dec) > sum) return {1'b1, {CNT_W{1'b0}}};
        return {1'b0, diff[CNT_W-1:0]};
    endfunction

    logic s_rs1_use, s_rs2_use, s_rd_use;
    logic s_wb_ok, s_kill_ok;
    logic s_rs1_busy, s_rs2_busy, v_rs1_busy, v_rs2_busy;
    logic rd_full, tot_full, stall_c, issue_c;
    logic [1:0] n_dest;
    logic [2:0] n_rel;
    logic [TOT_W:0] tot_sum;
    logic [TOT_W:0] tot_diff;

    assign s_rs1_use = sb.dec_s_rs1_en & s_track(sb.dec_s_rs1);
    assign s_rs2_use = sb.dec_s_rs2_en & s_track(sb.dec_s_rs2);
    assign s_rd_use  = sb.dec_s_rd_en  & s_track(sb.dec_s_rd);
    assign s_wb_ok   = sb.wb_s_en      & s_track(sb.wb_s_addr);
    assign s_kill_ok = sb.kill_s_en    & s_track(sb.kill_s_addr);

    always_comb begin
        s_rs1_busy = s_rs1_use && s_cnt[sb.dec_s_rs1] != '0;
        s_rs2_busy = s_rs2_use && s_cnt[sb.dec_s_rs2] != '0;
        v_rs1_busy = sb.dec_v_rs1_en && v_cnt[sb.dec_v_rs1] != '0;
        v_rs2_busy = sb.dec_v_rs2_en && v_cnt[sb.dec_v_rs2] != '0;
`ifdef WB_BYPASS_EN
        // Register file forwards the retiring data, so the last write is not a hazard.
        if (s_cnt[sb.dec_s_rs1] == CNT_W'(1) && s_wb_ok && sb.wb_s_addr == sb.dec_s_rs1)
            s_rs1_busy = 1'b0;
        if (s_cnt[sb.dec_s_rs2] == CNT_W'(1) && s_wb_ok && sb.wb_s_addr == sb.dec_s_rs2)
            s_rs2_busy = 1'b0;
        if (v_cnt[sb.dec_v_rs1] == CNT_W'(1) && sb.wb_v_en && sb.wb_v_addr == sb.dec_v_rs1)
            v_rs1_busy = 1'b0;
        if (v_cnt[sb.dec_v_rs2] == CNT_W'(1) && sb.wb_v_en && sb.wb_v_addr == sb.dec_v_rs2)
            v_rs2_busy = 1'b0;
`endif
    end

    // Two dests issued at max-1 would also overflow the total, so count the dests.
    assign n_dest   = 2'(s_rd_use) + 2'(sb.dec_v_rd_en);
    assign tot_full = ({1'b0, total} + (TOT_W+1)'(n_dest)) > TOT_MAX;
    assign rd_full  = (s_rd_use && s_cnt[sb.dec_s_rd] == CNT_MAX)
                    | (sb.dec_v_rd_en && v_cnt[sb.dec_v_rd] == CNT_MAX);
    assign stall_c  = sb.dec_valid & (s_rs1_busy | s_rs2_busy | v_rs1_busy
                    | v_rs2_busy | rd_full | tot_full);
    assign issue_c  = sb.dec_valid & ~stall_c;

    always_comb begin
        s_uf = '0;
        v_uf = '0;
        for (int i = 0; i < 32; i++) begin
            {s_uf[i], s_nxt[i]} = cnt_upd(s_cnt[i],
                issue_c & s_rd_use & (sb.dec_s_rd == 5'(i)),
                2'(s_wb_ok & (sb.wb_s_addr == 5'(i)))
                + 2'(s_kill_ok & (sb.kill_s_addr == 5'(i))));
            {v_uf[i], v_nxt[i]} = cnt_upd(v_cnt[i],
                issue_c & sb.dec_v_rd_en & (sb.dec_v_rd == 5'(i)),
                2'(sb.wb_v_en & (sb.wb_v_addr == 5'(i)))
                + 2'(sb.kill_v_en & (sb.kill_v_addr == 5'(i))));
        end
    end

    assign n_rel    = 3'(s_wb_ok) + 3'(s_kill_ok)
                    + 3'(sb.wb_v_en) + 3'(sb.kill_v_en);
    assign tot_sum  = {1'b0, total} + (TOT_W+1)'(issue_c ? n_dest : 2'd0);
    assign tot_diff = tot_sum - (TOT_W+1)'(n_rel);
    assign tot_uf   = (TOT_W+1)'(n_rel) > tot_sum;
    assign tot_nxt  = tot_uf ? '0 : tot_diff[TOT_W-1:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 32; i++) begin
                s_cnt[i] <= '0;
                v_cnt[i] <= '0;
            end
            total <= '0;
            err_q <= 1'b0;
        end else begin
            for (int i = 0; i < 32; i++) begin
                s_cnt[i] <= s_nxt[i];
                v_cnt[i] <= v_nxt[i];
            end
            total <= tot_nxt;
            if (|s_uf || |v_uf || tot_uf) err_q <= 1'b1;
        end
    end

    always_comb begin
        sb.s_pending = '0;
        sb.v_pending = '0;
        for (int i = 0; i < 32; i++) begin
            sb.s_pending[i] = s_cnt[i] != '0;
            sb.v_pending[i] = v_cnt[i] != '0;
        end
    end

    assign sb.stall         = stall_c;
    assign sb.issue         = issue_c;
    assign sb.idle          = total == '0;
    assign sb.err_underflow = err_q;
endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed test of reg_scoreboard: hazards, saturation, release netting,
// underflow and the r0 exemption; define WB_BYPASS_EN to check the bypass build.
module tb_reg_scoreboard;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_chk = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    reg_scoreboard_if sb();

    reg_scoreboard dut (
        .clk  (clk),
        .rst_n(rst_n),
        .sb   (sb)
    );

`ifdef WB_BYPASS_EN
    localparam logic BYP_STALL = 1'b0;
`else
    localparam logic BYP_STALL = 1'b1;
`endif

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic clr;
        sb.dec_valid = 0;
        sb.dec_s_rs1_en = 0; sb.dec_s_rs2_en = 0;
        sb.dec_s_rs1 = 0;    sb.dec_s_rs2 = 0;
        sb.dec_v_rs1_en = 0; sb.dec_v_rs2_en = 0;
        sb.dec_v_rs1 = 0;    sb.dec_v_rs2 = 0;
        sb.dec_s_rd_en = 0;  sb.dec_v_rd_en = 0;
        sb.dec_s_rd = 0;     sb.dec_v_rd = 0;
        sb.wb_s_en = 0;      sb.wb_v_en = 0;
        sb.wb_s_addr = 0;    sb.wb_v_addr = 0;
        sb.kill_s_en = 0;    sb.kill_v_en = 0;
        sb.kill_s_addr = 0;  sb.kill_v_addr = 0;
    endtask

    // Advance one clock, then clear inputs and let outputs settle.
    task automatic cyc;
        @(posedge clk);
        #1;
        clr();
        #1;
    endtask

    task automatic s_issue(input logic [4:0] rd);
        sb.dec_valid = 1; sb.dec_s_rd_en = 1; sb.dec_s_rd = rd;
        #1;
    endtask

    task automatic s_wb(input logic [4:0] a);
        sb.wb_s_en = 1; sb.wb_s_addr = a;
        #1;
    endtask

    initial begin
        clr();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        #1;
        check("rst_s_pend", sb.s_pending, 32'h0);
        check("rst_v_pend", sb.v_pending, 32'h0);
        check("rst_idle", 32'(sb.idle), 1);
        check("rst_err", 32'(sb.err_underflow), 0);
        check("rst_stall", 32'(sb.stall), 0);
        check("rst_issue", 32'(sb.issue), 0);

        sb.dec_valid = 1; sb.dec_s_rs1_en = 1; sb.dec_s_rs1 = 3;
        #1;
        check("nodest_stall", 32'(sb.stall), 0);
        check("nodest_issue", 32'(sb.issue), 1);
        cyc();
        check("nodest_idle", 32'(sb.idle), 1);

        // RAW on scalar r5
        s_issue(5);
        check("s5_issue", 32'(sb.issue), 1);
        cyc();
        check("s5_pend", sb.s_pending, 32'h0000_0020);
        check("s5_notidle", 32'(sb.idle), 0);
        sb.dec_valid = 1; sb.dec_s_rs1_en = 1; sb.dec_s_rs1 = 5;
        #1;
        check("s5_raw_stall", 32'(sb.stall), 1);
        check("s5_raw_issue", 32'(sb.issue), 0);
        s_wb(5);
        check("s5_wb_stall", 32'(sb.stall), 32'(BYP_STALL));
        cyc();
        check("s5_clr_pend", sb.s_pending, 32'h0);
        check("s5_clr_idle", 32'(sb.idle), 1);
        sb.dec_valid = 1; sb.dec_s_rs1_en = 1; sb.dec_s_rs1 = 5;
        #1;
        check("s5_after_stall", 32'(sb.stall), 0);
        cyc();

        // Vector r5 must not block scalar r5
        sb.dec_valid = 1; sb.dec_v_rd_en = 1; sb.dec_v_rd = 5;
        #1;
        cyc();
        check("v5_pend", sb.v_pending, 32'h0000_0020);
        check("v5_s_pend", sb.s_pending, 32'h0);
        sb.dec_valid = 1; sb.dec_v_rs1_en = 1; sb.dec_v_rs1 = 5;
        sb.dec_s_rs1_en = 1; sb.dec_s_rs1 = 5;
        #1;
        check("v5_raw_stall", 32'(sb.stall), 1);
        sb.dec_v_rs1_en = 0;
        #1;
        check("s5_indep_stall", 32'(sb.stall), 0);
        check("s5_indep_issue", 32'(sb.issue), 1);
        cyc();
        sb.wb_v_en = 1; sb.wb_v_addr = 5;
        cyc();
        check("v5_clr_pend", sb.v_pending, 32'h0);
        check("v5_clr_idle", 32'(sb.idle), 1);

        // WAW saturation on scalar r7; issue+wb in one cycle nets out
        s_issue(7); cyc();
        s_issue(7); cyc();
        s_issue(7); s_wb(7);
        check("s7_net_issue", 32'(sb.issue), 1);
        cyc();
        s_issue(7);
        check("s7_third_issue", 32'(sb.issue), 1);
        cyc();
        s_issue(7);
        check("s7_sat_stall", 32'(sb.stall), 1);
        check("s7_sat_issue", 32'(sb.issue), 0);
        cyc();
        s_wb(7); cyc();
        s_wb(7); cyc();
        check("s7_one_left", sb.s_pending, 32'h0000_0080);
        s_wb(7); cyc();
        check("s7_drained", sb.s_pending, 32'h0);
        check("s7_idle", 32'(sb.idle), 1);
        check("s7_no_err", 32'(sb.err_underflow), 0);

        // wb and kill together on r9
        s_issue(9); cyc();
        s_issue(9); cyc();
        check("s9_pend2", sb.s_pending, 32'h0000_0200);
        s_wb(9); sb.kill_s_en = 1; sb.kill_s_addr = 9;
        cyc();
        check("s9_dbl_pend", sb.s_pending, 32'h0);
        check("s9_dbl_idle", 32'(sb.idle), 1);
        check("s9_dbl_err", 32'(sb.err_underflow), 0);
        s_issue(9); cyc();
        s_wb(9); sb.kill_s_en = 1; sb.kill_s_addr = 9;
        cyc();
        check("s9_uf_pend", sb.s_pending, 32'h0);
        check("s9_uf_idle", 32'(sb.idle), 1);
        check("s9_uf_err", 32'(sb.err_underflow), 1);
        cyc(); cyc();
        check("s9_err_sticky", 32'(sb.err_underflow), 1);

        // Scalar r0 is untracked
        s_issue(0);
        check("r0_issue", 32'(sb.issue), 1);
        cyc();
        check("r0_pend", sb.s_pending, 32'h0);
        check("r0_idle", 32'(sb.idle), 1);
        sb.dec_valid = 1; sb.dec_s_rs1_en = 1; sb.dec_s_rs1 = 0;
        #1;
        check("r0_src_stall", 32'(sb.stall), 0);
        cyc();

        // Reset drops in-flight state and the sticky error
        s_issue(12); cyc();
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        #1;
        check("rst2_pend", sb.s_pending, 32'h0);
        check("rst2_err", 32'(sb.err_underflow), 0);
        check("rst2_idle", 32'(sb.idle), 1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end
endmodule
